// File: rtl/seq_mul_accumulate.sv
// Sequential shift-add multiplier / multiply-accumulator: one partial product per clock,
// start/busy/done handshake, optional accumulation into mul_sum with carry out.
module seq_mul_accumulate #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 acc_clr,
    input  logic [WIDTH-1:0]     i_1,
    input  logic [WIDTH-1:0]     i_2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   mul_sum,
    output logic                 carryout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_next;
    logic [2*WIDTH-1:0]   mcand_sh;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   partial_next;
    logic [WIDTH-1:0]     mult_sh;
    logic                 mode_q;
    logic [CW-1:0]        count;
    logic                 last_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        last_step    = 1'b0;
        partial_next = partial + (mult_sh[0] ? mcand_sh : '0);
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                if (count == LAST) begin
                    last_step  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // Operands are shifted rather than indexed: bit k of the multiplier is always at mult_sh[0]
    // and the multiplicand is pre-shifted by k, which is the same as testing mult_q[k].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_sh <= '0;
            mult_sh  <= '0;
            mode_q   <= 1'b0;
            partial  <= '0;
            count    <= '0;
            done     <= 1'b0;
            mul_sum  <= '0;
            carryout <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (acc_clr) begin
                    mul_sum  <= '0;
                    carryout <= 1'b0;
                end
                if (start) begin
                    mcand_sh <= {{WIDTH{1'b0}}, i_1};
                    mult_sh  <= i_2;
                    mode_q   <= mode;
                    partial  <= '0;
                    count    <= '0;
                end
            end else begin
                partial  <= partial_next;
                mcand_sh <= mcand_sh << 1;
                mult_sh  <= mult_sh >> 1;
                count    <= count + CW'(1);
                if (last_step) begin
                    done <= 1'b1;
                    if (mode_q) begin
                        {carryout, mul_sum} <= {1'b0, mul_sum} + {1'b0, partial_next};
                    end else begin
                        mul_sum  <= partial_next;
                        carryout <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_mul_accumulate.sv
// Scoreboard bench for seq_mul_accumulate: directed WIDTH=16 vectors plus an exhaustive
// WIDTH=4 sweep; monitors pop expected results on every done pulse.
module tb_seq_mul_accumulate;

    typedef struct {
        logic [31:0] sum;
        logic        c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, mode = 1'b0, acc_clr = 1'b0;
    logic [15:0] i_1 = '0, i_2 = '0;
    logic        busy, done, carryout;
    logic [31:0] mul_sum;

    logic        start4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4, carryout4;
    logic [7:0]  mul_sum4;

    exp_t q16[$];
    exp_t q4[$];
    int   n_checks = 0;
    int   n_fail = 0;

    seq_mul_accumulate #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .acc_clr(acc_clr),
        .i_1(i_1), .i_2(i_2), .busy(busy), .done(done),
        .mul_sum(mul_sum), .carryout(carryout)
    );

    seq_mul_accumulate #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(1'b0), .acc_clr(1'b0),
        .i_1(a4), .i_2(b4), .busy(busy4), .done(done4),
        .mul_sum(mul_sum4), .carryout(carryout4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Caller must be at a negedge; inputs are applied there and start drops just after the edge.
    task automatic issue(input logic m, input logic clr, input logic [15:0] a, input logic [15:0] b,
                         input logic push, input logic [31:0] e_sum, input logic e_c);
        exp_t e;
        start = 1'b1; mode = m; acc_clr = clr; i_1 = a; i_2 = b;
        if (push) begin
            e.sum = e_sum; e.c = e_c;
            q16.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0; acc_clr = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: done timeout, got no pulse expected one within 60 cycles", name);
        end
    endtask

    task automatic wait_done4();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done4) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL w4_done: timeout, got no pulse expected one within 20 cycles");
        end
    endtask

    // Monitor for the 16-bit instance: busy run length and result per done pulse.
    initial begin : mon16
        int run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else begin
                if (busy) run++;
                if (done) begin
                    check("busy_cycles", 32'(run), 32'd16);
                    run = 0;
                    if (q16.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1 expected no pending result, mul_sum=%h", mul_sum);
                    end else begin
                        e = q16.pop_front();
                        check("mul_sum", mul_sum, e.sum);
                        check("carryout", 32'(carryout), 32'(e.c));
                    end
                end
            end
        end
    end

    initial begin : mon4
        int run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else begin
                if (busy4) run++;
                if (done4) begin
                    check("w4_busy_cycles", 32'(run), 32'd4);
                    run = 0;
                    if (q4.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL w4_unexpected_done: got done=1 expected none, mul_sum=%h", mul_sum4);
                    end else begin
                        e = q4.pop_front();
                        check("w4_mul_sum", 32'(mul_sum4), e.sum);
                        check("w4_carryout", 32'(carryout4), 32'(e.c));
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mul_sum", mul_sum, 32'd0);
        check("rst_carryout", 32'(carryout), 32'd0);
        check("rst_w4_mul_sum", 32'(mul_sum4), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1, 2: plain multiplies
        issue(1'b0, 1'b0, 16'd3, 16'd5, 1'b1, 32'd15, 1'b0);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done("t1");
        @(negedge clk);
        issue(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001, 1'b0);
        wait_done("t2");
        repeat (3) @(negedge clk);
        check("hold_mul_sum", mul_sum, 32'hFFFE0001);
        check("hold_done", 32'(done), 32'd0);

        // 3: clear, then MACs; the third shows carryout is not sticky
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        check("clr_mul_sum", mul_sum, 32'd0);
        check("clr_carryout", 32'(carryout), 32'd0);
        @(negedge clk);
        issue(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001, 1'b0);
        wait_done("t3a");
        @(negedge clk);
        issue(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFC0002, 1'b1);
        wait_done("t3b");
        @(negedge clk);
        issue(1'b1, 1'b0, 16'd1, 16'd1, 1'b1, 32'hFFFC0003, 1'b0);
        wait_done("t3c");

        // 4: inputs during RUN ignored; start in the done cycle accepted
        @(negedge clk);
        issue(1'b0, 1'b0, 16'd7, 16'd9, 1'b1, 32'd63, 1'b0);
        repeat (5) @(negedge clk);
        start = 1'b1; acc_clr = 1'b1; mode = 1'b1; i_1 = 16'd2; i_2 = 16'd2;
        repeat (2) @(negedge clk);
        start = 1'b0; acc_clr = 1'b0;
        wait_done("t4a");
        issue(1'b0, 1'b0, 16'd4, 16'd4, 1'b1, 32'd16, 1'b0);
        wait_done("t4b");

        // 5: reset mid-RUN aborts with no done
        @(negedge clk);
        issue(1'b0, 1'b0, 16'd5, 16'd5, 1'b0, 32'd0, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_mul_sum", mul_sum, 32'd0);
        check("abort_carryout", 32'(carryout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("abort_idle_busy", 32'(busy), 32'd0);
        issue(1'b0, 1'b0, 16'd6, 16'd7, 1'b1, 32'd42, 1'b0);
        wait_done("t5");

        // 6: clear and start together, accumulate onto zero
        @(negedge clk);
        issue(1'b1, 1'b1, 16'd7, 16'd9, 1'b1, 32'd63, 1'b0);
        wait_done("t6");

        // 7: WIDTH=4 exhaustive against a*b
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                @(negedge clk);
                start4 = 1'b1; a4 = 4'(a); b4 = 4'(b);
                e.sum = 32'(a * b); e.c = 1'b0;
                q4.push_back(e);
                @(posedge clk); #1;
                start4 = 1'b0;
                wait_done4();
            end
        end

        repeat (3) @(negedge clk);
        check("q16_drained", 32'(q16.size()), 32'd0);
        check("q4_drained", 32'(q4.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
